// File: rtl/monitor_collector_pkg.sv
// Shared types and sizing helpers for the monitor output collector.
package monitor_collector_pkg;

    // Drain-side FSM states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Stream-index width; at least one bit so a single-stream build still has a port
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed frame layout: {ts, aktv mask, values}
    function automatic int frame_w(input int ts_w, input int n, input int dw);
        return ts_w + n + n * dw;
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// Single-clock frame FIFO. Pointers and count reset; storage does not.
module collector_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push at full is legal only when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Frame storage
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/monitor_output_collector.sv
// Captures active monitor output cycles as timestamped frames and drains
// them as (ts, idx, value) words over a valid/ready stream.
module monitor_output_collector
    import monitor_collector_pkg::*;
#(
    parameter int NUM_OUTPUTS = 3,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0]     out_data,
    input  logic [NUM_OUTPUTS-1:0]            out_aktv,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    output logic [DATA_W-1:0]                 tx_data,
    output logic [idx_w(NUM_OUTPUTS)-1:0]     tx_idx,
    output logic [TS_W-1:0]                   tx_ts,
    output logic                              tx_last,
    output logic                              overflow,
    output logic [15:0]                       drop_cnt
);
    localparam int IDX_W = idx_w(NUM_OUTPUTS);
    localparam int FW    = frame_w(TS_W, NUM_OUTPUTS, DATA_W);
    localparam int VW    = NUM_OUTPUTS * DATA_W;

    state_e                 state_q, state_d;
    logic [TS_W-1:0]        ts_q;
    logic [TS_W-1:0]        fts_q;
    logic [NUM_OUTPUTS-1:0] mask_q, mask_d;
    logic [VW-1:0]          fdata_q;
    logic                   overflow_q;
    logic [15:0]            drop_q;

    logic                   push_req, push_ok, pop;
    logic                   fifo_full, fifo_empty;
    logic [FW-1:0]          fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_unused;

    logic [IDX_W-1:0]       sel_idx;
    logic [NUM_OUTPUTS-1:0] sel_oh;
    logic [DATA_W-1:0]      sel_data;
    logic                   sel_last, xfer, done;

    // Capture: any active stream with en high forms a frame
    assign push_req = en && (|out_aktv);
    assign push_ok  = push_req && (!fifo_full || pop);

    collector_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_ok),
        .wdata_i ({ts_q, out_aktv, out_data}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_unused)
    );

    // Pick the lowest remaining active stream of the current frame
    always_comb begin
        sel_idx  = '0;
        sel_oh   = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (mask_q[k] && (sel_oh == '0)) begin
                sel_idx   = IDX_W'(k);
                sel_oh[k] = 1'b1;
                sel_data  = fdata_q[k*DATA_W +: DATA_W];
            end
        end
        sel_last = ((mask_q & ~sel_oh) == '0);
    end

    assign xfer = (state_q == SEND) && tx_ready;
    assign done = xfer && sel_last;
    // Load the next frame when idle, or straight after the last word (no bubble)
    assign pop  = !fifo_empty && ((state_q == IDLE) || done);

    // FSM and mask next-state
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (pop) begin
            state_d = SEND;
            mask_d  = fifo_rdata[VW +: NUM_OUTPUTS];
        end else if (done) begin
            state_d = IDLE;
            mask_d  = '0;
        end else if (xfer) begin
            mask_d  = mask_q & ~sel_oh;
        end
    end

    // Drain-side state and frame register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            fts_q   <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (pop) begin
                fts_q   <= fifo_rdata[FW-1 -: TS_W];
                fdata_q <= fifo_rdata[VW-1:0];
            end
        end
    end

    // Timestamp counter and drop bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (en) ts_q <= ts_q + TS_W'(1);
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Word outputs are zero whenever nothing is presented
    assign tx_valid = (state_q == SEND);
    assign tx_data  = tx_valid ? sel_data : '0;
    assign tx_idx   = tx_valid ? sel_idx  : '0;
    assign tx_ts    = tx_valid ? fts_q    : '0;
    assign tx_last  = tx_valid && sel_last;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_monitor_output_collector.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks transfers.
module tb_monitor_output_collector;
    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [191:0] out_data;
    logic [2:0]   out_aktv;
    logic         tx_valid;
    logic         tx_ready;
    logic [63:0]  tx_data;
    logic [1:0]   tx_idx;
    logic [31:0]  tx_ts;
    logic         tx_last;
    logic         overflow;
    logic [15:0]  drop_cnt;

    typedef struct packed {
        logic [31:0] ts;
        logic [1:0]  idx;
        logic [63:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_ts = 0;

    monitor_output_collector dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out_data (out_data),
        .out_aktv (out_aktv),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_idx   (tx_idx),
        .tx_ts    (tx_ts),
        .tx_last  (tx_last),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Queue the words a frame should produce, lowest index first
    task automatic expect_frame(input logic [31:0] ts, input logic [2:0] a,
                                input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
        logic [63:0] d [3];
        int hi;
        d[0] = d0; d[1] = d1; d[2] = d2;
        hi = a[2] ? 2 : (a[1] ? 1 : 0);
        for (int k = 0; k < 3; k++)
            if (a[k]) exp_q.push_back('{ts: ts, idx: 2'(k), data: d[k], last: (k == hi)});
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1
    task automatic cyc(input logic e, input logic [2:0] a, input logic [63:0] d0,
                       input logic [63:0] d1, input logic [63:0] d2, input bit want);
        en       = e;
        out_aktv = a;
        out_data = {d2, d1, d0};
        if (want) expect_frame(model_ts, a, d0, d1, d2);
        @(posedge clk);
        #1;
        if (e) model_ts = model_ts + 32'd1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compare every accepted word against the scoreboard head
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word idx=%0d data=%0h ts=%0d", tx_idx, tx_data, tx_ts);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("word_ts",   64'(tx_ts),   64'(w.ts));
                chk("word_idx",  64'(tx_idx),  64'(w.idx));
                chk("word_data", tx_data,      w.data);
                chk("word_last", 64'(tx_last), 64'(w.last));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] s_data;
        logic [1:0]  s_idx;
        logic [31:0] s_ts;
        logic        s_last;

        rst = 1'b1; en = 1'b0; out_aktv = '0; out_data = '0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    64'(tx_valid), 0);
        chk("rst_last",     64'(tx_last),  0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_drop",     64'(drop_cnt), 0);
        chk("rst_data",     tx_data,       0);
        chk("rst_ts",       64'(tx_ts),    0);
        rst = 1'b0;
        model_ts = 0;

        // Single frame after 1000 enabled cycles, ts = 1000
        repeat (1000) cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
        expect_frame(32'd1000, 3'b111, 1, 1, 1);
        cyc(1'b1, 3'b111, 1, 1, 1, 1'b0);
        chk("lat_edge1_valid", 64'(tx_valid), 0);
        cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
        chk("lat_edge2_valid", 64'(tx_valid), 1);
        drain();

        // Sparse mask: stream 1 must never appear
        cyc(1'b1, 3'b101, 7, 64'h55, 9, 1'b1);
        drain();

        // Backpressure: outputs hold while stalled
        tx_ready = 1'b0;
        cyc(1'b1, 3'b111, 11, 12, 13, 1'b1);
        for (int i = 0; i < 5 && !tx_valid; i++) cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
        chk("bp_valid_up", 64'(tx_valid), 1);
        s_data = tx_data; s_idx = tx_idx; s_ts = tx_ts; s_last = tx_last;
        repeat (5) begin
            cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
            chk("bp_valid", 64'(tx_valid), 1);
            chk("bp_data",  tx_data,       s_data);
            chk("bp_idx",   64'(tx_idx),   64'(s_idx));
            chk("bp_ts",    64'(tx_ts),    64'(s_ts));
            chk("bp_last",  64'(tx_last),  64'(s_last));
        end
        tx_ready = 1'b1;
        drain();

        // Overflow: one stalled frame in the frame register, then 10 frames; 9 and 10 drop
        tx_ready = 1'b0;
        cyc(1'b1, 3'b001, 100, 0, 0, 1'b1);
        for (int v = 1; v <= 10; v++) cyc(1'b1, 3'b001, 64'(v), 0, 0, (v <= 8));
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_drop", 64'(drop_cnt), 2);

        // Push and pop in the same cycle at full: capture accepted
        tx_ready = 1'b1;
        cyc(1'b1, 3'b001, 20, 0, 0, 1'b1);
        chk("pp_drop", 64'(drop_cnt), 2);
        chk("pp_flag", 64'(overflow), 1);
        drain();

        // en gating: nothing captured, timestamp frozen
        repeat (5) cyc(1'b0, 3'b111, 1, 2, 3, 1'b0);
        chk("en0_valid", 64'(tx_valid), 0);
        cyc(1'b1, 3'b111, 21, 22, 23, 1'b1);
        drain();

        // Reset mid-SEND discards the frame and FIFO contents
        tx_ready = 1'b0;
        cyc(1'b1, 3'b111, 31, 32, 33, 1'b0);
        cyc(1'b1, 3'b111, 41, 42, 43, 1'b0);
        for (int i = 0; i < 5 && !tx_valid; i++) cyc(1'b1, 3'b000, 0, 0, 0, 1'b0);
        chk("rs_valid_pre", 64'(tx_valid), 1);
        en = 1'b0; out_aktv = '0;
        #2 rst = 1'b1;
        #1;
        chk("rs_valid",    64'(tx_valid), 0);
        chk("rs_last",     64'(tx_last),  0);
        chk("rs_overflow", 64'(overflow), 0);
        chk("rs_drop",     64'(drop_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_ts = 0;
        tx_ready = 1'b1;
        repeat (4) cyc(1'b0, 3'b000, 0, 0, 0, 1'b0);
        chk("rs_fifo_empty", 64'(tx_valid), 0);
        cyc(1'b1, 3'b001, 50, 0, 0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
